// File: rtl/pc_bpred_if.sv
// Fetch-side bundle for pc_bpred.
// Purpose : groups the fetch handshake, the redirect inputs and the
//           branch-update strobe so the PC block and its neighbours share
//           one typed connection.
// Modports: master - the PC generator (drives fetch_*; receives ready,
//                    redirects and branch updates)
//           slave  - the IF/EX/trap side (the mirror image)
// Signals : fetch_ready, fetch_valid, fetch_pc, fetch_pred_taken,
//           fetch_pred_target, trap_take, trap_pc, mispredict, redirect_pc,
//           bu_valid, bu_pc, bu_taken, bu_target
interface pc_bpred_if #(
  parameter int PC_WIDTH = 32
);
  logic                fetch_ready;
  logic                fetch_valid;
  logic [PC_WIDTH-1:0] fetch_pc;
  logic                fetch_pred_taken;
  logic [PC_WIDTH-1:0] fetch_pred_target;
  logic                trap_take;
  logic [PC_WIDTH-1:0] trap_pc;
  logic                mispredict;
  logic [PC_WIDTH-1:0] redirect_pc;
  logic                bu_valid;
  logic [PC_WIDTH-1:0] bu_pc;
  logic                bu_taken;
  logic [PC_WIDTH-1:0] bu_target;

  modport master (
    output fetch_valid, fetch_pc, fetch_pred_taken, fetch_pred_target,
    input  fetch_ready, trap_take, trap_pc, mispredict, redirect_pc,
           bu_valid, bu_pc, bu_taken, bu_target
  );

  modport slave (
    input  fetch_valid, fetch_pc, fetch_pred_taken, fetch_pred_target,
    output fetch_ready, trap_take, trap_pc, mispredict, redirect_pc,
           bu_valid, bu_pc, bu_taken, bu_target
  );
endinterface

// File: rtl/pc_bpred.sv
// pc_bpred - fetch program counter with optional branch target buffer.
// Purpose : holds the fetch PC, offers it to IF under a valid/ready
//           handshake and selects the next PC from trap, mispredict
//           redirect, BTB prediction or sequential step.
// Ports   : clk - clock
//           rst - synchronous active-high reset
//           bp  - pc_bpred_if.master (fetch handshake, redirects, updates)
// Option  : define PC_BTB_EN to build the direct-mapped BTB with 2-bit
//           saturating counters. Without it the prediction outputs are 0,
//           bu_* is ignored and next-PC is trap > mispredict > step > hold.
module pc_bpred #(
  parameter int                  PC_WIDTH   = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC   = '0,
  parameter int                  INST_BYTES = 4,
  parameter int                  BTB_DEPTH  = 16
) (
  input logic        clk,
  input logic        rst,
  pc_bpred_if.master bp
);
  localparam int OFS_W = $clog2(INST_BYTES);
  localparam int IDX_W = $clog2(BTB_DEPTH);
  localparam int TAG_W = PC_WIDTH - IDX_W - OFS_W;
  localparam logic [PC_WIDTH-1:0] STEP       = PC_WIDTH'(INST_BYTES);
  localparam logic [PC_WIDTH-1:0] ALIGN_MASK = ~PC_WIDTH'(INST_BYTES - 1);

  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic                valid_q;
  logic                accept;
  logic                pred_taken;
  logic [PC_WIDTH-1:0] pred_target;

  assign accept = valid_q & bp.fetch_ready;

  // Redirects win even without a handshake; stalled fetch holds the PC.
  always_comb begin
    pc_d = pc_q;
    if (bp.trap_take)
      pc_d = bp.trap_pc & ALIGN_MASK;
    else if (bp.mispredict)
      pc_d = bp.redirect_pc & ALIGN_MASK;
    else if (accept && pred_taken)
      pc_d = pred_target;
    else if (accept)
      pc_d = pc_q + STEP;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= RESET_PC;
      valid_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      valid_q <= 1'b1;
    end
  end

  assign bp.fetch_valid       = valid_q;
  assign bp.fetch_pc          = pc_q;
  assign bp.fetch_pred_taken  = pred_taken;
  assign bp.fetch_pred_target = pred_target;

`ifdef PC_BTB_EN
  logic [BTB_DEPTH-1:0] btb_v_q;
  logic [TAG_W-1:0]     btb_tag_q [BTB_DEPTH];
  logic [PC_WIDTH-1:0]  btb_tgt_q [BTB_DEPTH];
  logic [1:0]           btb_ctr_q [BTB_DEPTH];

  logic [IDX_W-1:0] lk_idx, up_idx;
  logic [TAG_W-1:0] lk_tag, up_tag;
  logic             lk_hit, up_hit;
  logic             unused_bu;

  assign lk_idx = pc_q[OFS_W +: IDX_W];
  assign lk_tag = pc_q[PC_WIDTH-1 -: TAG_W];
  assign lk_hit = btb_v_q[lk_idx] && (btb_tag_q[lk_idx] == lk_tag);

  assign pred_taken  = lk_hit && btb_ctr_q[lk_idx][1];
  assign pred_target = pred_taken ? btb_tgt_q[lk_idx] : '0;

  assign up_idx = bp.bu_pc[OFS_W +: IDX_W];
  assign up_tag = bp.bu_pc[PC_WIDTH-1 -: TAG_W];
  assign up_hit = btb_v_q[up_idx] && (btb_tag_q[up_idx] == up_tag);

  // Offset bits of a branch PC never select an entry.
  assign unused_bu = ^bp.bu_pc[OFS_W-1:0];

  // Only the valid bits need reset; tag/target/ctr are qualified by them.
  always_ff @(posedge clk) begin
    if (rst)
      btb_v_q <= '0;
    else if (bp.bu_valid && !up_hit && bp.bu_taken)
      btb_v_q[up_idx] <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst && bp.bu_valid) begin
      if (up_hit) begin
        if (bp.bu_taken) begin
          btb_tgt_q[up_idx] <= bp.bu_target & ALIGN_MASK;
          if (btb_ctr_q[up_idx] != 2'd3)
            btb_ctr_q[up_idx] <= btb_ctr_q[up_idx] + 2'd1;
        end else if (btb_ctr_q[up_idx] != 2'd0) begin
          btb_ctr_q[up_idx] <= btb_ctr_q[up_idx] - 2'd1;
        end
      end else if (bp.bu_taken) begin
        // Allocation evicts whatever aliased into this slot, weakly taken.
        btb_tag_q[up_idx] <= up_tag;
        btb_tgt_q[up_idx] <= bp.bu_target & ALIGN_MASK;
        btb_ctr_q[up_idx] <= 2'd2;
      end
    end
  end
`else
  logic unused_bu;

  assign pred_taken  = 1'b0;
  assign pred_target = '0;
  assign unused_bu   = ^{bp.bu_valid, bp.bu_pc, bp.bu_taken, bp.bu_target};
`endif

endmodule

// File: tb/tb_pc_bpred.sv
module tb_pc_bpred;
`ifdef PC_BTB_EN
  localparam bit BTB_ON = 1'b1;
`else
  localparam bit BTB_ON = 1'b0;
`endif

  logic clk;
  logic rst;

  pc_bpred_if #(.PC_WIDTH(32)) bpi ();
  pc_bpred_if #(.PC_WIDTH(8))  bps ();

  pc_bpred #(
    .PC_WIDTH(32), .RESET_PC(32'h100), .INST_BYTES(4), .BTB_DEPTH(16)
  ) dut (
    .clk(clk), .rst(rst), .bp(bpi)
  );

  pc_bpred #(
    .PC_WIDTH(8), .RESET_PC(8'hF8), .INST_BYTES(4), .BTB_DEPTH(16)
  ) dut_small (
    .clk(clk), .rst(rst), .bp(bps)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst, rdy, trap;
    logic [31:0] tpc;
    logic        mis;
    logic [31:0] rpc;
    logic        bv;
    logic [31:0] bpc;
    logic        bt;
    logic [31:0] btg;
    logic [31:0] epc;
    logic        ev, et;
    logic [31:0] etg;
  } vec_t;

  typedef struct {
    string       name;
    logic [31:0] pc;
    logic        v, t;
    logic [31:0] tgt;
  } exp_t;

  vec_t vecs[$];
  exp_t sbq[$];
  int   n_vec  = 0;
  int   n_fail = 0;

  function automatic vec_t mk(input logic r, input logic rd, input logic tr,
                              input logic [31:0] tpc, input logic mi,
                              input logic [31:0] rpc, input logic bv,
                              input logic [31:0] bpc, input logic bt,
                              input logic [31:0] btg, input logic [31:0] epc,
                              input logic ev, input logic et,
                              input logic [31:0] etg);
    vec_t v;
    v.rst = r;  v.rdy = rd; v.trap = tr; v.tpc = tpc; v.mis = mi; v.rpc = rpc;
    v.bv = bv;  v.bpc = bpc; v.bt = bt; v.btg = btg;
    v.epc = epc; v.ev = ev; v.et = et; v.etg = etg;
    return v;
  endfunction

  task automatic push_exp(input string nm, input logic [31:0] pc,
                          input logic v, input logic t, input logic [31:0] tgt);
    exp_t e;
    e.name = nm; e.pc = pc; e.v = v; e.t = t; e.tgt = tgt;
    sbq.push_back(e);
  endtask

  task automatic check_pop(input logic [31:0] a_pc, input logic a_v,
                           input logic a_t, input logic [31:0] a_tgt);
    exp_t e;
    n_vec++;
    if (sbq.size() == 0) begin
      n_fail++;
      $display("FAIL sb_empty: got pc=%h with no expected entry queued", a_pc);
    end else begin
      e = sbq.pop_front();
      if (a_pc !== e.pc || a_v !== e.v || a_t !== e.t || a_tgt !== e.tgt) begin
        n_fail++;
        $display("FAIL %s: got pc=%h valid=%b taken=%b target=%h, want pc=%h valid=%b taken=%b target=%h",
                 e.name, a_pc, a_v, a_t, a_tgt, e.pc, e.v, e.t, e.tgt);
      end
    end
  endtask

  task automatic check_main();
    check_pop(bpi.fetch_pc, bpi.fetch_valid, bpi.fetch_pred_taken,
              bpi.fetch_pred_target);
  endtask

  task automatic check_small();
    check_pop({24'h0, bps.fetch_pc}, bps.fetch_valid, bps.fetch_pred_taken,
              {24'h0, bps.fetch_pred_target});
  endtask

  logic [7:0] small_pc [4];
  logic       small_v  [4];

  initial begin
    // Expected outputs observed before each clock edge (epc/ev/et/etg).
    //            rst rdy trp tpc      mis rpc      bv bpc      bt btg       epc                   ev et      etg
    vecs.push_back(mk(0,1,0,32'h0,  0,32'h0,  0,32'h0, 0,32'h0,  32'h100,1'b0,0,32'h0));
    vecs.push_back(mk(0,1,0,32'h0,  0,32'h0,  0,32'h0, 0,32'h0,  32'h100,1'b1,0,32'h0));
    vecs.push_back(mk(0,1,0,32'h0,  0,32'h0,  0,32'h0, 0,32'h0,  32'h104,1'b1,0,32'h0));
    vecs.push_back(mk(0,1,0,32'h0,  0,32'h0,  0,32'h0, 0,32'h0,  32'h108,1'b1,0,32'h0));
    vecs.push_back(mk(0,0,1,32'h20, 0,32'h0,  0,32'h0, 0,32'h0,  32'h10C,1'b1,0,32'h0));
    vecs.push_back(mk(0,0,0,32'h0,  0,32'h0,  0,32'h0, 0,32'h0,  32'h20, 1'b1,0,32'h0));
    vecs.push_back(mk(0,0,0,32'h0,  0,32'h0,  0,32'h0, 0,32'h0,  32'h20, 1'b1,0,32'h0));
    vecs.push_back(mk(0,0,0,32'h0,  0,32'h0,  0,32'h0, 0,32'h0,  32'h20, 1'b1,0,32'h0));
    vecs.push_back(mk(0,1,0,32'h0,  0,32'h0,  0,32'h0, 0,32'h0,  32'h20, 1'b1,0,32'h0));
    vecs.push_back(mk(0,0,0,32'h0,  0,32'h0,  0,32'h0, 0,32'h0,  32'h24, 1'b1,0,32'h0));
    vecs.push_back(mk(0,1,1,32'h800,1,32'h400,0,32'h0, 0,32'h0,  32'h24, 1'b1,0,32'h0));
    vecs.push_back(mk(0,1,0,32'h0,  1,32'h403,0,32'h0, 0,32'h0,  32'h800,1'b1,0,32'h0));
    vecs.push_back(mk(0,0,0,32'h0,  0,32'h0,  0,32'h0, 0,32'h0,  32'h400,1'b1,0,32'h0));
    vecs.push_back(mk(0,0,1,32'h123,0,32'h0,  0,32'h0, 0,32'h0,  32'h400,1'b1,0,32'h0));
    vecs.push_back(mk(0,0,0,32'h0,  0,32'h0,  0,32'h0, 0,32'h0,  32'h120,1'b1,0,32'h0));
    // BTB: allocate 0x40 -> 0x80 alongside a trap to 0x40.
    vecs.push_back(mk(0,0,1,32'h40, 0,32'h0,  1,32'h40,1,32'h80, 32'h120,1'b1,0,32'h0));
    vecs.push_back(mk(0,0,0,32'h0,  0,32'h0,  0,32'h0, 0,32'h0,  32'h40, 1'b1,BTB_ON,BTB_ON ? 32'h80 : 32'h0));
    vecs.push_back(mk(0,1,0,32'h0,  0,32'h0,  0,32'h0, 0,32'h0,  32'h40, 1'b1,BTB_ON,BTB_ON ? 32'h80 : 32'h0));
    vecs.push_back(mk(0,0,1,32'h40, 0,32'h0,  1,32'h40,0,32'h0,  BTB_ON ? 32'h80 : 32'h44,1'b1,0,32'h0));
    vecs.push_back(mk(0,0,0,32'h0,  0,32'h0,  1,32'h40,0,32'h0,  32'h40, 1'b1,0,32'h0));
    vecs.push_back(mk(0,1,0,32'h0,  0,32'h0,  0,32'h0, 0,32'h0,  32'h40, 1'b1,0,32'h0));
    // Counter floor at 0, then climb back to weakly taken.
    vecs.push_back(mk(0,0,1,32'h40, 0,32'h0,  1,32'h40,0,32'h0,  32'h44, 1'b1,0,32'h0));
    vecs.push_back(mk(0,0,0,32'h0,  0,32'h0,  1,32'h40,1,32'h90, 32'h40, 1'b1,0,32'h0));
    vecs.push_back(mk(0,0,0,32'h0,  0,32'h0,  1,32'h40,1,32'h88, 32'h40, 1'b1,0,32'h0));
    vecs.push_back(mk(0,0,0,32'h0,  0,32'h0,  0,32'h0, 0,32'h0,  32'h40, 1'b1,BTB_ON,BTB_ON ? 32'h88 : 32'h0));
    // Aliasing: 0x80 shares index 0 with 0x40.
    vecs.push_back(mk(0,0,1,32'h80, 0,32'h0,  0,32'h0, 0,32'h0,  32'h40, 1'b1,BTB_ON,BTB_ON ? 32'h88 : 32'h0));
    vecs.push_back(mk(0,0,0,32'h0,  0,32'h0,  1,32'h80,1,32'hC7, 32'h80, 1'b1,0,32'h0));
    vecs.push_back(mk(0,0,1,32'h40, 0,32'h0,  0,32'h0, 0,32'h0,  32'h80, 1'b1,BTB_ON,BTB_ON ? 32'hC4 : 32'h0));
    vecs.push_back(mk(0,1,0,32'h0,  0,32'h0,  0,32'h0, 0,32'h0,  32'h40, 1'b1,0,32'h0));
    vecs.push_back(mk(0,0,1,32'h80, 0,32'h0,  1,32'h40,0,32'h0,  32'h44, 1'b1,0,32'h0));
    vecs.push_back(mk(0,0,0,32'h0,  0,32'h0,  0,32'h0, 0,32'h0,  32'h80, 1'b1,BTB_ON,BTB_ON ? 32'hC4 : 32'h0));
    // Reset mid-run overrides the trap and clears the BTB.
    vecs.push_back(mk(1,1,1,32'h500,0,32'h0,  0,32'h0, 0,32'h0,  32'h80, 1'b1,BTB_ON,BTB_ON ? 32'hC4 : 32'h0));
    vecs.push_back(mk(0,0,1,32'h80, 0,32'h0,  0,32'h0, 0,32'h0,  32'h100,1'b0,0,32'h0));
    vecs.push_back(mk(0,0,0,32'h0,  0,32'h0,  0,32'h0, 0,32'h0,  32'h80, 1'b1,0,32'h0));
    vecs.push_back(mk(0,1,0,32'h0,  0,32'h0,  0,32'h0, 0,32'h0,  32'h80, 1'b1,0,32'h0));
    vecs.push_back(mk(0,0,0,32'h0,  0,32'h0,  0,32'h0, 0,32'h0,  32'h84, 1'b1,0,32'h0));

    small_pc[0] = 8'hF8; small_v[0] = 1'b0;
    small_pc[1] = 8'hF8; small_v[1] = 1'b1;
    small_pc[2] = 8'hFC; small_v[2] = 1'b1;
    small_pc[3] = 8'h00; small_v[3] = 1'b1;

    rst = 1'b1;
    bpi.fetch_ready = 1'b0; bpi.trap_take = 1'b0; bpi.trap_pc = '0;
    bpi.mispredict = 1'b0; bpi.redirect_pc = '0; bpi.bu_valid = 1'b0;
    bpi.bu_pc = '0; bpi.bu_taken = 1'b0; bpi.bu_target = '0;
    bps.fetch_ready = 1'b0; bps.trap_take = 1'b0; bps.trap_pc = '0;
    bps.mispredict = 1'b0; bps.redirect_pc = '0; bps.bu_valid = 1'b0;
    bps.bu_pc = '0; bps.bu_taken = 1'b0; bps.bu_target = '0;
    repeat (2) @(negedge clk);

    push_exp("reset_main", 32'h100, 1'b0, 1'b0, 32'h0);
    #1 check_main();
    push_exp("reset_small", 32'hF8, 1'b0, 1'b0, 32'h0);
    check_small();

    // 8-bit PC wraps from 0xFC to 0x00.
    rst = 1'b0;
    bps.fetch_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      push_exp($sformatf("wrap8_%0d", k), {24'h0, small_pc[k]}, small_v[k], 1'b0, 32'h0);
      #1 check_small();
      @(negedge clk);
    end

    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < vecs.size(); i++) begin
      rst             = vecs[i].rst;
      bpi.fetch_ready = vecs[i].rdy;
      bpi.trap_take   = vecs[i].trap;
      bpi.trap_pc     = vecs[i].tpc;
      bpi.mispredict  = vecs[i].mis;
      bpi.redirect_pc = vecs[i].rpc;
      bpi.bu_valid    = vecs[i].bv;
      bpi.bu_pc       = vecs[i].bpc;
      bpi.bu_taken    = vecs[i].bt;
      bpi.bu_target   = vecs[i].btg;
      push_exp($sformatf("vec%0d", i + 1), vecs[i].epc, vecs[i].ev,
               vecs[i].et, vecs[i].etg);
      #1 check_main();
      @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
